// File: rtl/cpu_pkg.sv
// Shared types and constants for the cpu_addr_seq bus sequencer and its mode decoder.
package cpu_pkg;

    typedef enum logic [3:0] {
        VEC_LO,
        VEC_HI,
        FETCH,
        OP1,
        OP2,
        IDX,
        IND_LO,
        IND_HI,
        FIX,
        EXEC
    } seq_state_t;

    typedef enum logic [3:0] {
        MODE_IMPL,
        MODE_IMM,
        MODE_ZP,
        MODE_ZPX,
        MODE_ABS,
        MODE_ABSX,
        MODE_ABSY,
        MODE_INDX,
        MODE_INDY
    } addr_mode_t;

    typedef enum logic [1:0] {
        IDX_NONE,
        IDX_X,
        IDX_Y
    } idx_sel_t;

    // Only the cc=01 opcode group carries memory addressing modes.
    localparam logic [1:0] CC_GROUP1 = 2'b01;

    localparam logic [2:0] BBB_INDX = 3'b000;
    localparam logic [2:0] BBB_ZP   = 3'b001;
    localparam logic [2:0] BBB_IMM  = 3'b010;
    localparam logic [2:0] BBB_ABS  = 3'b011;
    localparam logic [2:0] BBB_INDY = 3'b100;
    localparam logic [2:0] BBB_ZPX  = 3'b101;
    localparam logic [2:0] BBB_ABSY = 3'b110;
    localparam logic [2:0] BBB_ABSX = 3'b111;

    localparam logic [7:0] OP_RESET = 8'h00;

endpackage

// File: rtl/cpu_mode_decode.sv
// Combinational opcode decoder: addressing mode and index register select.
// The aaa field (opcode bits 7:5) never affects addressing, so only bits 4:0 come in.
module cpu_mode_decode
    import cpu_pkg::*;
(
    input  logic [4:0] op_low,
    output addr_mode_t mode,
    output idx_sel_t   idx_sel
);

    always_comb begin
        mode    = MODE_IMPL;
        idx_sel = IDX_NONE;
        if (op_low[1:0] == CC_GROUP1) begin
            case (op_low[4:2])
                BBB_INDX: begin
                    mode    = MODE_INDX;
                    idx_sel = IDX_X;
                end
                BBB_ZP:   mode = MODE_ZP;
                BBB_IMM:  mode = MODE_IMM;
                BBB_ABS:  mode = MODE_ABS;
                BBB_INDY: begin
                    mode    = MODE_INDY;
                    idx_sel = IDX_Y;
                end
                BBB_ZPX:  begin
                    mode    = MODE_ZPX;
                    idx_sel = IDX_X;
                end
                BBB_ABSY: begin
                    mode    = MODE_ABSY;
                    idx_sel = IDX_Y;
                end
                BBB_ABSX: begin
                    mode    = MODE_ABSX;
                    idx_sel = IDX_X;
                end
            endcase
        end
    end

endmodule

// File: rtl/cpu_addr_seq.sv
// Multi-cycle bus sequencer for a 6502-class core: vector fetch, opcode/operand fetch, EA calc.
// Define CPU_INDIRECT_EN to build the (zp,X) and (zp),Y pointer cycles; otherwise those modes flag ill_op.
module cpu_addr_seq
    import cpu_pkg::*;
#(
    parameter logic [15:0] RESET_VEC  = 16'hFFFC,
    parameter logic [7:0]  DP_PAGE    = 8'h00,
    parameter int          ALWAYS_FIX = 0
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        ready,
    input  logic [7:0]  d_in,
    input  logic [7:0]  x_idx,
    input  logic [7:0]  y_idx,
    input  logic        pc_load,
    input  logic [15:0] pc_load_val,
    output logic [15:0] addr,
    output logic        sync,
    output logic [7:0]  ir,
    output logic        op_valid,
    output logic [15:0] ea,
    output logic        ill_op
);

    localparam bit FORCE_FIX = (ALWAYS_FIX != 0);

    seq_state_t  state, state_nx;
    logic [15:0] pc, pc_nx;
    logic [7:0]  adl, adl_nx;
    logic [7:0]  adh, adh_nx;
    logic [7:0]  ir_nx;
    logic        carry, carry_nx;

    addr_mode_t  mode;
    idx_sel_t    idx_sel;
    logic [4:0]  dec_op;
    logic [7:0]  idx_val;
    logic [8:0]  idx_sum;
    logic [15:0] zp_addr;
    logic        unsupported;

`ifdef CPU_INDIRECT_EN
    logic [7:0]  tl, tl_nx;
    logic [7:0]  adl_inc;
    logic [8:0]  ind_sum;

    assign adl_inc     = adl + 8'd1;
    assign ind_sum     = {1'b0, tl} + {1'b0, y_idx};
    assign unsupported = 1'b0;
`else
    assign unsupported = (mode == MODE_INDX) || (mode == MODE_INDY);
`endif

    // In FETCH the opcode is still on the bus; afterwards the latched ir describes the instruction.
    assign dec_op  = (state == FETCH) ? d_in[4:0] : ir[4:0];
    assign zp_addr = {DP_PAGE, adl};
    assign idx_sum = {1'b0, adl} + {1'b0, idx_val};

    cpu_mode_decode u_decode (
        .op_low  (dec_op),
        .mode    (mode),
        .idx_sel (idx_sel)
    );

    always_comb begin
        idx_val = 8'h00;
        case (idx_sel)
            IDX_X:   idx_val = x_idx;
            IDX_Y:   idx_val = y_idx;
            default: idx_val = 8'h00;
        endcase
    end

    always_comb begin
        ea = {adh, adl};
        case (mode)
            MODE_IMPL, MODE_IMM: ea = pc;
            MODE_ZP, MODE_ZPX:   ea = zp_addr;
`ifdef CPU_INDIRECT_EN
            MODE_INDX, MODE_INDY: ea = {adh, adl};
`else
            MODE_INDX, MODE_INDY: ea = zp_addr;
`endif
            default: ea = {adh, adl};
        endcase
    end

    always_comb begin
        addr     = pc;
        sync     = 1'b0;
        op_valid = 1'b0;
        ill_op   = 1'b0;
        case (state)
            VEC_LO: addr = RESET_VEC;
            VEC_HI: addr = RESET_VEC + 16'd1;
            FETCH:  sync = 1'b1;
            IDX:    addr = zp_addr;
`ifdef CPU_INDIRECT_EN
            IND_LO: addr = zp_addr;
            IND_HI: addr = {DP_PAGE, adl_inc};
`endif
            FIX:    addr = {adh, adl};
            EXEC: begin
                addr     = ea;
                op_valid = (mode != MODE_IMPL) && !unsupported;
                ill_op   = unsupported;
            end
            default: addr = pc;
        endcase
    end

    // Every register holds while ready is low, which also keeps addr/ea stable through a stall.
    always_comb begin
        state_nx = state;
        pc_nx    = pc;
        adl_nx   = adl;
        adh_nx   = adh;
        ir_nx    = ir;
        carry_nx = carry;
`ifdef CPU_INDIRECT_EN
        tl_nx    = tl;
`endif
        if (ready) begin
            case (state)
                VEC_LO: begin
                    pc_nx    = {pc[15:8], d_in};
                    state_nx = VEC_HI;
                end
                VEC_HI: begin
                    pc_nx    = {d_in, pc[7:0]};
                    state_nx = FETCH;
                end
                FETCH: begin
                    ir_nx = d_in;
                    if (mode != MODE_IMPL) pc_nx = pc + 16'd1;
                    state_nx = ((mode == MODE_IMM) || (mode == MODE_IMPL)) ? EXEC : OP1;
                end
                OP1: begin
                    adl_nx = d_in;
                    pc_nx  = pc + 16'd1;
                    case (mode)
                        MODE_ABS, MODE_ABSX, MODE_ABSY: state_nx = OP2;
                        MODE_ZPX:  state_nx = IDX;
`ifdef CPU_INDIRECT_EN
                        MODE_INDX: state_nx = IDX;
                        MODE_INDY: state_nx = IND_LO;
`endif
                        default:   state_nx = EXEC;
                    endcase
                end
                IDX: begin
                    adl_nx   = adl + x_idx;
                    state_nx = EXEC;
`ifdef CPU_INDIRECT_EN
                    if (mode == MODE_INDX) state_nx = IND_LO;
`endif
                end
                OP2: begin
                    adh_nx              = d_in;
                    pc_nx               = pc + 16'd1;
                    {carry_nx, adl_nx}  = idx_sum;
                    state_nx = ((idx_sel != IDX_NONE) && (idx_sum[8] || FORCE_FIX)) ? FIX : EXEC;
                end
                FIX: begin
                    adh_nx   = adh + {7'd0, carry};
                    state_nx = EXEC;
                end
`ifdef CPU_INDIRECT_EN
                IND_LO: begin
                    tl_nx    = d_in;
                    state_nx = IND_HI;
                end
                IND_HI: begin
                    adh_nx = d_in;
                    if (mode == MODE_INDX) begin
                        adl_nx   = tl;
                        state_nx = EXEC;
                    end else begin
                        {carry_nx, adl_nx} = ind_sum;
                        state_nx = (ind_sum[8] || FORCE_FIX) ? FIX : EXEC;
                    end
                end
`endif
                EXEC: begin
                    if (mode == MODE_IMM) pc_nx = pc + 16'd1;
                    if (pc_load) pc_nx = pc_load_val;
                    state_nx = FETCH;
                end
                default: state_nx = VEC_LO;
            endcase
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state <= VEC_LO;
            pc    <= 16'h0000;
            adl   <= 8'h00;
            adh   <= 8'h00;
            ir    <= OP_RESET;
            carry <= 1'b0;
        end else begin
            state <= state_nx;
            pc    <= pc_nx;
            adl   <= adl_nx;
            adh   <= adh_nx;
            ir    <= ir_nx;
            carry <= carry_nx;
        end
    end

`ifdef CPU_INDIRECT_EN
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) tl <= 8'h00;
        else        tl <= tl_nx;
    end
`endif

endmodule

// File: tb/tb_cpu_addr_seq.sv
// Randomized self-checking bench for cpu_addr_seq against a per-instruction bus-cycle reference model.
module tb_cpu_addr_seq;

    localparam logic [15:0] RESET_VEC  = 16'hFFFC;
    localparam logic [7:0]  DP         = 8'h00;
    localparam int          ALWAYS_FIX = 0;

    logic        clk;
    logic        reset;
    logic        ready;
    logic [7:0]  d_in;
    logic [7:0]  x_idx;
    logic [7:0]  y_idx;
    logic        pc_load;
    logic [15:0] pc_load_val;
    logic [15:0] addr;
    logic        sync;
    logic [7:0]  ir;
    logic        op_valid;
    logic [15:0] ea;
    logic        ill_op;

    logic [7:0]  mem [0:65535];
    logic [15:0] exp_q[$];
    logic [15:0] model_pc;
    logic [15:0] last_ea;
    logic        last_ov;
    logic        last_ill;

    int check_count = 0;
    int fail_count  = 0;

    logic [7:0]  r_op;
    logic [7:0]  r_b1;
    logic [7:0]  r_b2;
    int          r_stall;

    cpu_addr_seq #(
        .RESET_VEC  (RESET_VEC),
        .DP_PAGE    (DP),
        .ALWAYS_FIX (ALWAYS_FIX)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .ready       (ready),
        .d_in        (d_in),
        .x_idx       (x_idx),
        .y_idx       (y_idx),
        .pc_load     (pc_load),
        .pc_load_val (pc_load_val),
        .addr        (addr),
        .sync        (sync),
        .ir          (ir),
        .op_valid    (op_valid),
        .ea          (ea),
        .ill_op      (ill_op)
    );

    assign d_in = mem[addr];

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input logic [15:0] got, input logic [15:0] want);
        check_count++;
        if (got !== want) begin
            fail_count++;
            $display("[TB] FAIL %s: got %h expected %h at %0t", tag, got, want, $time);
        end
    endtask

    // Bus address of every cycle of one instruction, derived from the mode's cycle table.
    task automatic buildExpected(input logic [15:0] pc0, input logic [7:0] op, input logic [7:0] xv,
                                 input logic [7:0] yv, output logic [15:0] e_ea, output logic e_ov,
                                 output logic e_ill, output logic [15:0] n_pc);
        logic [7:0] b1, b2, idx, sum_lo, hi;
        logic [8:0] sum;
`ifdef CPU_INDIRECT_EN
        logic [7:0] lo_ptr, hi_ptr, base_lo, base_hi;
`endif
        exp_q.delete();
        b1    = mem[pc0 + 16'd1];
        b2    = mem[pc0 + 16'd2];
        e_ov  = 1'b1;
        e_ill = 1'b0;
        n_pc  = pc0 + 16'd2;
        exp_q.push_back(pc0);
        if (op[1:0] != 2'b01) begin
            e_ea = pc0;
            e_ov = 1'b0;
            n_pc = pc0;
        end else begin
            case (op[4:2])
                3'b010: e_ea = pc0 + 16'd1;
                3'b001: begin
                    exp_q.push_back(pc0 + 16'd1);
                    e_ea = {DP, b1};
                end
                3'b101: begin
                    exp_q.push_back(pc0 + 16'd1);
                    exp_q.push_back({DP, b1});
                    sum_lo = b1 + xv;
                    e_ea = {DP, sum_lo};
                end
                3'b011: begin
                    exp_q.push_back(pc0 + 16'd1);
                    exp_q.push_back(pc0 + 16'd2);
                    e_ea = {b2, b1};
                    n_pc = pc0 + 16'd3;
                end
                3'b110, 3'b111: begin
                    idx = op[2] ? xv : yv;
                    sum = {1'b0, b1} + {1'b0, idx};
                    exp_q.push_back(pc0 + 16'd1);
                    exp_q.push_back(pc0 + 16'd2);
                    if (sum[8] || (ALWAYS_FIX != 0)) exp_q.push_back({b2, sum[7:0]});
                    hi = b2 + {7'd0, sum[8]};
                    e_ea = {hi, sum[7:0]};
                    n_pc = pc0 + 16'd3;
                end
                default: begin
`ifdef CPU_INDIRECT_EN
                    exp_q.push_back(pc0 + 16'd1);
                    if (op[4] == 1'b0) begin
                        exp_q.push_back({DP, b1});
                        lo_ptr = b1 + xv;
                    end else begin
                        lo_ptr = b1;
                    end
                    hi_ptr  = lo_ptr + 8'd1;
                    exp_q.push_back({DP, lo_ptr});
                    exp_q.push_back({DP, hi_ptr});
                    base_lo = mem[{DP, lo_ptr}];
                    base_hi = mem[{DP, hi_ptr}];
                    if (op[4] == 1'b0) begin
                        e_ea = {base_hi, base_lo};
                    end else begin
                        sum = {1'b0, base_lo} + {1'b0, yv};
                        if (sum[8] || (ALWAYS_FIX != 0)) exp_q.push_back({base_hi, sum[7:0]});
                        hi = base_hi + {7'd0, sum[8]};
                        e_ea = {hi, sum[7:0]};
                    end
`else
                    exp_q.push_back(pc0 + 16'd1);
                    e_ea  = {DP, b1};
                    e_ov  = 1'b0;
                    e_ill = 1'b1;
`endif
                end
            endcase
        end
        exp_q.push_back(e_ea);
    endtask

    // Places one instruction at the model PC and walks it cycle by cycle, optionally stalling.
    task automatic applyStimulus(input logic [7:0] op, input logic [7:0] b1, input logic [7:0] b2,
                                 input logic [7:0] xv, input logic [7:0] yv, input int stall_at,
                                 input logic do_load, input logic [15:0] load_val);
        logic [15:0] e_ea, n_pc;
        logic        e_ov, e_ill;
        int          n;
        mem[model_pc]          = op;
        mem[model_pc + 16'd1]  = b1;
        mem[model_pc + 16'd2]  = b2;
        x_idx = xv;
        y_idx = yv;
        buildExpected(model_pc, op, xv, yv, e_ea, e_ov, e_ill, n_pc);
        n = exp_q.size();
        for (int c = 0; c < n; c++) begin
            checkOutput("addr", addr, exp_q[c]);
            checkOutput("sync", {15'd0, sync}, (c == 0) ? 16'd1 : 16'd0);
            if (c == 1) checkOutput("ir", {8'd0, ir}, {8'd0, op});
            if (c == n - 1) begin
                checkOutput("exec_ea", ea, e_ea);
                checkOutput("op_valid", {15'd0, op_valid}, {15'd0, e_ov});
                checkOutput("ill_op", {15'd0, ill_op}, {15'd0, e_ill});
                last_ea  = ea;
                last_ov  = op_valid;
                last_ill = ill_op;
            end
            if (c == stall_at) begin
                for (int k = 0; k < 3; k++) begin
                    ready       = 1'b0;
                    pc_load     = 1'($urandom_range(0, 1));
                    pc_load_val = 16'($urandom);
                    @(posedge clk);
                    @(negedge clk);
                    checkOutput("stall_addr", addr, exp_q[c]);
                    checkOutput("stall_sync", {15'd0, sync}, (c == 0) ? 16'd1 : 16'd0);
                end
            end
            ready       = 1'b1;
            pc_load     = do_load && (c == n - 1);
            pc_load_val = load_val;
            @(posedge clk);
            @(negedge clk);
            pc_load = 1'b0;
        end
        model_pc = do_load ? load_val : n_pc;
    endtask

    // Asserts reset mid-cycle, then walks the two vector cycles; called at a falling edge.
    task automatic doReset(input logic [7:0] lo, input logic [7:0] hi);
        mem[RESET_VEC]         = lo;
        mem[RESET_VEC + 16'd1] = hi;
        #2 reset = 1'b0;
        #1;
        checkOutput("rst_addr", addr, RESET_VEC);
        checkOutput("rst_sync", {15'd0, sync}, 16'd0);
        checkOutput("rst_op_valid", {15'd0, op_valid}, 16'd0);
        checkOutput("rst_ill_op", {15'd0, ill_op}, 16'd0);
        checkOutput("rst_ir", {8'd0, ir}, 16'h0000);
        checkOutput("rst_ea", ea, 16'h0000);
        @(negedge clk);
        reset = 1'b1;
        ready = 1'b1;
        checkOutput("vec_lo_addr", addr, RESET_VEC);
        @(posedge clk);
        @(negedge clk);
        checkOutput("vec_hi_addr", addr, RESET_VEC + 16'd1);
        checkOutput("vec_hi_sync", {15'd0, sync}, 16'd0);
        @(posedge clk);
        @(negedge clk);
        model_pc = {hi, lo};
    endtask

    initial begin
        reset       = 1'b0;
        ready       = 1'b1;
        x_idx       = 8'h00;
        y_idx       = 8'h00;
        pc_load     = 1'b0;
        pc_load_val = 16'h0000;
        model_pc    = 16'h0000;
        for (int i = 0; i < 65536; i++) mem[i] = 8'($urandom);

        @(negedge clk);
        doReset(8'h00, 8'h80);

        applyStimulus(8'hA9, 8'h55, 8'h00, 8'h00, 8'h00, -1, 1'b1, 16'h8000);
        checkOutput("imm_ea", last_ea, 16'h8001);
        applyStimulus(8'hBD, 8'hFF, 8'h12, 8'h01, 8'h00, -1, 1'b1, 16'h8000);
        checkOutput("absx_cross_ea", last_ea, 16'h1300);
        applyStimulus(8'hBD, 8'hFF, 8'h12, 8'h00, 8'h00, -1, 1'b1, 16'h8000);
        checkOutput("absx_nocross_ea", last_ea, 16'h12FF);
        applyStimulus(8'hB5, 8'hF0, 8'h00, 8'h20, 8'h00, -1, 1'b1, 16'h8000);
        checkOutput("zpx_wrap_ea", last_ea, 16'h0010);
        applyStimulus(8'hAD, 8'h34, 8'h12, 8'h00, 8'h00, 2, 1'b1, 16'h8000);
        checkOutput("stall_abs_ea", last_ea, 16'h1234);

        mem[16'h0040] = 8'hFF;
        mem[16'h0041] = 8'h20;
        applyStimulus(8'hB1, 8'h40, 8'h00, 8'h00, 8'h01, -1, 1'b1, 16'h8000);
`ifdef CPU_INDIRECT_EN
        checkOutput("indy_ea", last_ea, 16'h2100);
        checkOutput("indy_ill", {15'd0, last_ill}, 16'd0);
`else
        checkOutput("indy_ea", last_ea, 16'h0040);
        checkOutput("indy_ill", {15'd0, last_ill}, 16'd1);
`endif

        applyStimulus(8'hBD, 8'hF0, 8'hFF, 8'h20, 8'h00, -1, 1'b1, 16'hFFFF);
        checkOutput("adh_wrap_ea", last_ea, 16'h0010);
        applyStimulus(8'hA9, 8'h11, 8'h22, 8'h00, 8'h00, -1, 1'b0, 16'h0000);
        checkOutput("pc_wrap_ea", last_ea, 16'h0000);
        applyStimulus(8'hEA, 8'h00, 8'h00, 8'h00, 8'h00, 1, 1'b0, 16'h0000);
        checkOutput("impl_ea", last_ea, 16'h0001);
        checkOutput("impl_op_valid", {15'd0, last_ov}, 16'd0);

        for (int i = 0; i < 400; i++) begin
            if (i == 200) doReset(8'h34, 8'h12);
            r_op = 8'($urandom);
            if ($urandom_range(0, 3) != 0) r_op[1:0] = 2'b01;
            r_b1    = 8'($urandom);
            r_b2    = 8'($urandom);
            r_stall = ($urandom_range(0, 5) == 0) ? int'($urandom_range(0, 5)) : -1;
            applyStimulus(r_op, r_b1, r_b2, 8'($urandom), 8'($urandom), r_stall,
                          ($urandom_range(0, 5) == 0), 16'($urandom));
        end

        $display("End of test - %0d assertions evaluated, %0d failures", check_count, fail_count);
        $finish;
    end

endmodule

// File: doc/cpu_addr_seq.md
Name: cpu_addr_seq

Overview:
- Parametrised successor to the single-FSM CPU controller: a multi-cycle bus sequencer for 6502-class cores.
- Fetches the reset vector, then the opcode and operands, and computes effective addresses for every cc=01 addressing mode, including zero-page wrap and page-cross fixup cycles.
- Presents the final operand cycle to the execute datapath.
- Sits between the memory bus and the ALU/register file inside cpu.

Parameters:
- RESET_VEC, 16'hFFFC, address of the reset vector low byte; the high byte is at RESET_VEC+1.
- DP_PAGE, 8'h00, high byte used for the "zero page" (direct page) base.
- ALWAYS_FIX, 0, 1 means abs,X/abs,Y and (zp),Y always take the fixup cycle (store timing); 0 means only on carry.

Ports:
- clk  in  1  system clock, rising edge.
- reset  in  1  asynchronous, active-low reset.
- ready  in  1  bus ready; 0 stalls the sequencer.
- d_in  in  8  read data, valid at the clock edge ending the cycle in which addr is driven.
- x_idx  in  8  X index register value.
- y_idx  in  8  Y index register value.
- pc_load  in  1  execute unit redirects PC; sampled in EXEC only.
- pc_load_val  in  16  new PC value.
- addr  out  16  bus address.
- sync  out  1  1 in the opcode fetch cycle.
- ir  out  8  latched opcode.
- op_valid  out  1  1 in EXEC for non-implied modes; d_in is the operand.
- ea  out  16  effective address; equals addr during EXEC.
- ill_op  out  1  one-cycle pulse in EXEC for an unsupported mode.

Behaviour:
- Reset (async, reset=0):
  - state goes to VEC_LO; PC, ADL, ADH and TL are cleared to 0; ir is set to 0x00.
  - sync=0, op_valid=0, ill_op=0; addr=RESET_VEC (combinational from state).
- Stall (ready=0): state and all registers hold; addr, sync, op_valid and ea are held stable; pc_load is ignored.
- Mode decode is taken from d_in during FETCH:
  - cc=01: modes by bbb are 000 (zp,X), 001 zp, 010 imm, 011 abs, 100 (zp),Y, 101 zp,X, 110 abs,Y, 111 abs,X.
  - cc!=01: implied.
- States and bus cycles (ready=1; "PC+" means PC increments):
  - VEC_LO: addr=RESET_VEC; PCL<=d_in; next VEC_HI.
  - VEC_HI: addr=RESET_VEC+1; PC<={d_in,PCL}; next FETCH.
  - FETCH: sync=1, addr=PC; ir<=d_in; PC+ unless implied.
    - imm or implied: next EXEC.
    - all other modes: next OP1.
  - OP1: addr=PC; ADL<=d_in; PC+.
    - abs, abs,X, abs,Y: next OP2.
    - zp: next EXEC.
    - zp,X and (zp,X): next IDX.
    - (zp),Y: next IND_LO.
  - IDX: dummy read at {DP_PAGE,ADL}; ADL<=ADL+x_idx mod 256 (never leaves the page); next EXEC, or IND_LO for (zp,X).
  - OP2: addr=PC; ADH<=d_in; PC+; ADL<=ADL+idx and latch the carry, where idx is x_idx, y_idx, or 0 for plain abs.
    - carry=1 or ALWAYS_FIX=1 (indexed modes only): next FIX.
    - otherwise: next EXEC.
  - FIX: dummy read at {ADH,ADL}; ADH<=ADH+carry mod 256; next EXEC.
  - EXEC, addr = ea:
    - imm and implied: ea=PC.
    - zp modes: ea={DP_PAGE,ADL}.
    - all others: ea={ADH,ADL}.
    - imm: PC+. Implied: no PC increment, op_valid=0.
    - pc_load=1 sets PC<=pc_load_val and overrides any increment.
    - next FETCH.
- Cycle counts: imm 2; implied 2; zp 3; zp,X 4; abs 4; abs,X/Y 4, or 5 on page cross; (zp,X) 6; (zp),Y 5, or 6 on page cross.
- Wrap rules:
  - PC wraps 0xFFFF to 0x0000.
  - ADH in FIX wraps 0xFF to 0x00, so the address wraps to page 0.
- Reset asserted in any state aborts the current cycle immediately; the sequence restarts at VEC_LO after release.

Optional Feature:
- Macro: CPU_INDIRECT_EN.
- Defined:
  - IND_LO: addr={DP_PAGE,ADL}; TL<=d_in.
  - IND_HI: addr={DP_PAGE,ADL+1 mod 256}; ADH<=d_in.
    - (zp,X): ADL<=TL; next EXEC.
    - (zp),Y: ADL<=TL+y_idx and latch the carry; FIX and EXEC follow the abs,Y rules.
- Undefined:
  - bbb=000 and bbb=100 (cc=01) sequence as zp: FETCH, OP1, EXEC.
  - EXEC drives ill_op=1 and op_valid=0.
  - IND_LO and IND_HI are not built.

Decomposition:
- Package cpu_pkg holds:
  - the seq_state_t enum (VEC_LO, VEC_HI, FETCH, OP1, OP2, IDX, IND_LO, IND_HI, FIX, EXEC);
  - the addr_mode_t enum;
  - bbb mode constants and the NOP/reset opcode constant.
- One sub-module: cpu_mode_decode, combinational, mapping opcode to addr_mode_t and the index select.

Test Plan:
- Vector fetch: memory[FFFC]=0x00, memory[FFFD]=0x80; release reset → addr FFFC, then FFFD, then 8000 with sync=1 on cycle 3.
- Immediate: A9 at 8000 → FETCH@8000, EXEC@8001 with op_valid=1; next sync@8002; 2 cycles total.
- abs,X page cross: BD FF 12 with x_idx=01 → reads 8000, 8001, 8002; FIX dummy read @1200; EXEC@1300; 5 cycles. Same with x_idx=00 → EXEC@12FF in 4 cycles.
- zp,X wrap: B5 F0 with x_idx=20, DP_PAGE=00 → IDX dummy read @00F0; EXEC@0010, not 0110.
- Stall: hold ready=0 for 3 cycles during OP2 of AD 34 12 → addr stays 8002 and state holds; EXEC@1234 one cycle after ready returns.
- Indirect (with CPU_INDIRECT_EN): B1 40, memory[0040]=FF, memory[0041]=20, y_idx=01 → IND_LO@0040, IND_HI@0041, FIX@2000, EXEC@2100; 6 cycles. Without the macro → EXEC@0040 with ill_op=1.
